// File: rtl/i2so_pkg.sv
// Shared constants and frame-geometry helpers for the i2so output path.
package i2so_pkg;

  localparam logic FMT_I2S = 1'b0;
  localparam logic FMT_LJ  = 1'b1;

  function automatic int unsigned frame_len(input int unsigned num_ch, input int unsigned slot_w);
    return num_ch * slot_w;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned frame);
    return (frame > 1) ? $clog2(frame) : 1;
  endfunction

endpackage

// File: rtl/i2so_frame_hold.sv
// One-frame holding buffer between the sample source and the serializer.
// rtr is registered and tracks "buffer empty" as of the next cycle.
module i2so_frame_hold #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         rts_i,
  input  logic [W-1:0] data_i,
  input  logic         take_i,
  output logic         rtr_o,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q, full_d;
  logic         rtr_q, rtr_d;
  logic [W-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      rtr_q  <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      rtr_q  <= rtr_d;
      data_q <= data_d;
    end
  end

  // Clear wins over everything; a take and an accept never coincide since rtr is low while full.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clr_i) begin
      full_d = 1'b0;
      data_d = '0;
    end else if (take_i) begin
      full_d = 1'b0;
    end else if (rts_i && rtr_q) begin
      full_d = 1'b1;
      data_d = data_i;
    end
    rtr_d = !full_d;
  end

  assign rtr_o  = rtr_q;
  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/i2so_tdm_serializer.sv
// I2S / left-justified / TDM output serializer: frame buffer, position counter,
// MSB-first shifter and WS decode, with registered pad outputs.
module i2so_tdm_serializer
  import i2so_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SLOT_W = 16,
  parameter int unsigned NUM_CH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     fmt,
  input  logic                     sck_stb,
  input  logic                     rts,
  input  logic [NUM_CH*DATA_W-1:0] frame_data,
  output logic                     rtr,
  output logic                     i2so_sd,
  output logic                     i2so_ws,
  output logic                     underrun
);

  localparam int unsigned FW    = NUM_CH * DATA_W;
  localparam int unsigned FRAME = frame_len(NUM_CH, SLOT_W);
  localparam int unsigned CNT_W = cnt_width(FRAME);
  localparam int unsigned KW    = cnt_width(SLOT_W);
  localparam int unsigned SW    = cnt_width(NUM_CH);

  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(FRAME - 1);
  localparam logic [KW-1:0]    K_LAST = KW'(SLOT_W - 1);
  localparam logic [SW-1:0]    S_LAST = SW'(NUM_CH - 1);

  logic             hold_full;
  logic [FW-1:0]    hold_data;
  logic             load_c;

  logic [CNT_W-1:0] d_q, d_d;
  logic [KW-1:0]    k_q, k_d;
  logic [SW-1:0]    s_q, s_d;
  logic [FW-1:0]    sh_q, sh_d;
  logic             sd_q, sd_d;
  logic             ws_q, ws_d;
  logic             underrun_q, underrun_d;

  i2so_frame_hold #(
    .W(FW)
  ) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (!en),
    .rts_i  (rts),
    .data_i (frame_data),
    .take_i (load_c),
    .rtr_o  (rtr),
    .full_o (hold_full),
    .data_o (hold_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q        <= D_LAST;
      k_q        <= K_LAST;
      s_q        <= S_LAST;
      sh_q       <= '0;
      sd_q       <= 1'b0;
      ws_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      d_q        <= d_d;
      k_q        <= k_d;
      s_q        <= s_d;
      sh_q       <= sh_d;
      sd_q       <= sd_d;
      ws_q       <= ws_d;
      underrun_q <= underrun_d;
    end
  end

  // d tracks frame position; k/s are the same position split into bit-in-slot and slot.
  always_comb begin
    d_d        = d_q;
    k_d        = k_q;
    s_d        = s_q;
    sh_d       = sh_q;
    sd_d       = sd_q;
    ws_d       = ws_q;
    underrun_d = 1'b0;
    load_c     = 1'b0;
    if (!en) begin
      d_d  = D_LAST;
      k_d  = K_LAST;
      s_d  = S_LAST;
      sh_d = '0;
      sd_d = 1'b0;
      ws_d = 1'b0;
    end else if (sck_stb) begin
      d_d = (d_q == D_LAST) ? '0 : d_q + CNT_W'(1);
      if (k_q == K_LAST) begin
        k_d = '0;
        s_d = (s_q == S_LAST) ? '0 : s_q + SW'(1);
      end else begin
        k_d = k_q + KW'(1);
      end

      if (d_d == '0) begin
        load_c     = hold_full;
        underrun_d = !hold_full;
        sh_d       = hold_full ? hold_data : '0;
      end

      // Channel data is contiguous MSB-first in the shifter; padding slots emit 0 without shifting.
      if (32'(k_d) < DATA_W) begin
        sd_d = sh_d[FW-1];
        sh_d = sh_d << 1;
      end else begin
        sd_d = 1'b0;
      end

      if (NUM_CH == 2) begin
        if (fmt == FMT_I2S) ws_d = (k_d == K_LAST) ? ~s_d[0] : s_d[0];
        else                ws_d = ~s_d[0];
      end else begin
        if (fmt == FMT_LJ) ws_d = (d_d == '0);
        else               ws_d = (d_d == D_LAST);
      end
    end
  end

  assign i2so_sd  = sd_q;
  assign i2so_ws  = ws_q;
  assign underrun = underrun_q;

endmodule

// File: doc/i2so_tdm_serializer.md
# i2so_tdm_serializer

Parametrised I2S/TDM output serializer for the i2so path. It sits between the sample source and the pad, and takes whole frames of NUM_CH samples through an rts/rtr handshake into a one-frame holding buffer. It shifts each frame out MSB-first on the SCK drive edge, which arrives as a strobe already synchronised into the clk domain. It generates WS for standard I2S, left-justified and multi-slot TDM framing, and flags underruns.

## Interface
- DATA_W, 16: sample width in bits; 8..32.
- SLOT_W, 16: bits per slot; DATA_W ≤ SLOT_W ≤ 32.
- NUM_CH, 2: channels per frame; 2, 4, 6 or 8.

- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  serializer enable; fmt may change only while en=0.
- fmt  in  1  0 = I2S (one-bit delay), 1 = left-justified.
- sck_stb  in  1  one-clk pulse per SCK falling edge (drive edge).
- rts  in  1  frame_data valid.
- frame_data  in  NUM_CH*DATA_W  channel 0 in the MSBs, channel NUM_CH-1 in the LSBs.
- rtr  out  1  holding buffer empty, frame accepted when rts&&rtr.
- i2so_sd  out  1  serial data.
- i2so_ws  out  1  word select / frame sync.
- underrun  out  1  one-clk pulse when a frame starts with the buffer empty.

## Operation
- FRAME = NUM_CH*SLOT_W. Frame position counter d runs 0..FRAME-1 and wraps.
- Reset and en=0 both do the following:
  - set d=FRAME-1.
  - clear the shift register and the holding buffer (en=0 also discards held data).
  - drive i2so_sd=0, i2so_ws=0, underrun=0.
  - drive rtr=0 while rst_n=0. After release, rtr=1 in the first clk.
- Handshake: on rts&&rtr, frame_data is captured into the holding buffer and rtr falls on the next clk. rtr rises again in the clk after the buffer is loaded into the shift register.
- Each sck_stb with en=1 advances d to (d+1) mod FRAME.
- When d becomes 0:
  - If the holding buffer is full, it moves into the shift register.
  - Otherwise the shift register loads all-zero and underrun pulses.
- Data at position d: slot s = d/SLOT_W, bit k = d mod SLOT_W.
  - For k < DATA_W, sd = channel s bit (DATA_W-1-k).
  - Otherwise sd = 0 (padding).
- WS position w: w = (d+1) mod FRAME when fmt=0, so WS leads data by one SCK; w = d when fmt=1.
  - NUM_CH=2, fmt=0: ws = w/SLOT_W, low for channel 0.
  - NUM_CH=2, fmt=1: ws = !(w/SLOT_W), high for channel 0.
  - NUM_CH>2: ws = 1 only when w == 0 (one-SCK sync pulse), otherwise 0.
- Simultaneous rts&&rtr and load in the same clk cannot occur, because rtr=0 whenever the buffer is full.
- Strobes arriving less than 2 clk apart are out of range; behaviour is unspecified.

## Timing
- i2so_sd and i2so_ws are registered and change one clk after the sck_stb clock edge. They are stable until the next strobe.
- underrun is asserted in the clk in which d becomes 0.
- The first frame is accepted before the first strobe. It appears starting with the first strobe after en rises (d: FRAME-1 → 0).
- Latency from acceptance to its MSB on sd: one strobe after the next frame boundary.
- Sustained throughput: one frame per FRAME strobes. The source has FRAME-1 strobes after rtr rises to present the next frame.

## Structure
- Package i2so_pkg holds:
  - FMT_I2S=1'b0 and FMT_LJ=1'b1.
  - a function computing FRAME, and the counter width $clog2(FRAME).
- One sub-module, i2so_frame_hold: the holding buffer plus rts/rtr flag, parametrised on NUM_CH*DATA_W.
- The top module contains the position counter, shift/select logic, WS decode and output registers.

## Test plan
- Defaults, fmt=0, frame_data=32'hAAAA_FF00:
  - ws=0 for strobes 0..14, then 1 for strobes 15..30, then 0 from strobe 31.
  - sd bits are A,A,A,A,… then 1×8 and 0×8, in order MSB-first after the one-bit delay. No underrun.
- Same frame, fmt=1: ws=1 for strobes 0..15 and 0 for 16..31. sd=AAAA then FF00 with no delay.
- NUM_CH=4, SLOT_W=32, DATA_W=24, fmt=1, frames 24'h123456/ABCDEF/000001/800000:
  - ws pulses only at d=0.
  - Each slot is 24 data bits followed by 8 zero bits. One frame is 128 strobes.
- Underrun: rts stays 0 after the first frame. At the second boundary underrun pulses for 1 clk, sd=0 for the whole frame, and ws continues unchanged.
- Backpressure: rts=1 continuously with a new value each accept. rtr drops after each accept and rises exactly one clk after each boundary load. No frame is dropped or repeated.
- Reset asserted mid-slot (d=20): sd, ws, underrun and rtr go 0 immediately. After release, rtr=1 in the next clk and the next frame starts at d=0 on the first strobe.
